paula_iack_sequencer: RTL and testbench
=======================================

PAULA_IACK_SEQUENCER -- requirements
Module: paula_iack_sequencer

Parameters
REQ-001 The block SHALL have parameter VPA_DELAY, default 3, meaning the number of clk7_en ticks from IACK detection to VPA assertion; the legal range SHALL be 1..15.

Interface
REQ-002 The block SHALL have port clk, input, 1 bit: bus clock; the single clock for all logic.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port clk7_en, input, 1 bit: clock enable; all state SHALL advance only on clk edges where clk7_en=1.
REQ-005 The block SHALL have port ipl_n_in, input, 3 bits: active-low priority level from the interrupt controller (7 = none).
REQ-006 The block SHALL have port cpu_as_n, input, 1 bit: CPU address strobe, active low.
REQ-007 The block SHALL have port cpu_fc, input, 3 bits: CPU function code; 3'b111 = CPU space.
REQ-008 The block SHALL have port cpu_addr, input, 3 bits: CPU address bits 3:1; this is the level being acknowledged.
REQ-009 The block SHALL have port ipl_n_out, output, 3 bits: filtered IPL presented to the CPU.
REQ-010 The block SHALL have port vpa_n, output, 1 bit: autovector request, active low.
REQ-011 The block SHALL have port berr_n, output, 1 bit: bus error for a spurious IACK, active low.
REQ-012 The block SHALL have port iack_level, output, 3 bits: level of the last completed acknowledge.
REQ-013 The block SHALL have port iack_done, output, 1 bit: one-clk pulse, asserted only on a clk7_en cycle, when an autovector IACK completes.

Function
REQ-014 IPL filter: on each clk7_en tick, the block SHALL copy ipl_n_in into ipl_n_out only when ipl_n_in equals its value sampled on the previous tick, so a change propagates after exactly 2 ticks.
REQ-015 The block SHALL hold ipl_n_out frozen while state is not IDLE; the filter SHALL keep sampling during the freeze and apply stable values after return to IDLE.
REQ-016 IACK detect: in IDLE, a tick with cpu_as_n=0 and cpu_fc=3'b111 SHALL capture req_lvl=cpu_addr and pend_lvl=~ipl_n_out.
REQ-017 At detection, if req_lvl!=0 and req_lvl<=pend_lvl, the block SHALL load the delay counter with VPA_DELAY-1 and go to WAIT; otherwise it SHALL go to SPUR.
REQ-018 State WAIT: the counter SHALL decrement by 1 per tick; at 0 the block SHALL go to ACK with vpa_n=0 registered on that same tick.
REQ-019 In WAIT, cpu_as_n=1 SHALL abort the cycle: return to IDLE with no vpa_n, no iack_done, and no iack_level update.
REQ-020 State ACK: vpa_n SHALL stay 0 until a tick with cpu_as_n=1; on that tick vpa_n<=1, iack_level<=req_lvl, iack_done=1 for that clk only, and the next state SHALL be IDLE.
REQ-021 State SPUR: berr_n<=0 on entry and SHALL be held until a tick with cpu_as_n=1, then berr_n<=1 and the next state SHALL be IDLE; iack_done SHALL stay 0.
REQ-022 vpa_n and berr_n SHALL never be 0 simultaneously, and neither SHALL be 0 in IDLE.
REQ-023 A non-IACK bus cycle (cpu_fc!=7) SHALL never leave IDLE.
REQ-024 A new IACK SHALL be accepted no earlier than the tick after IDLE is re-entered; back-to-back IACKs therefore need cpu_as_n=1 for at least 1 tick between them.
REQ-025 The counter SHALL be 4 bits wide; with VPA_DELAY=1, ACK SHALL be entered on the tick after detection.

Reset
REQ-026 While reset=1, independent of clk7_en, the block SHALL force: ipl_n_out=3'b111, filter sample=3'b111, vpa_n=1, berr_n=1, iack_level=0, iack_done=0, state=IDLE, counter=0.
REQ-027 Reset asserted mid-cycle in WAIT, ACK or SPUR SHALL release vpa_n and berr_n immediately (asynchronously) with no iack_done.

Verification
REQ-028 Filter test: ipl_n_in 7->2 held, clk7_en every 4 clk -> ipl_n_out=2 after the 2nd tick; a 1-tick glitch 7->3->7 -> ipl_n_out stays 7.
REQ-029 Autovector test: ipl_n_out=2 (level 5), IACK with cpu_addr=5, VPA_DELAY=3 -> vpa_n=0 on the 3rd tick after detection; AS release -> iack_done single pulse, iack_level=5.
REQ-030 Spurious test: pending level 3, IACK cpu_addr=6 -> berr_n=0 the tick after detection, vpa_n stays 1, iack_done stays 0; with cpu_addr=0 the response SHALL be identical.
REQ-031 Abort test: cpu_as_n rises during WAIT -> IDLE, vpa_n never 0, iack_level unchanged.
REQ-032 Freeze test: ipl_n_in changes 2->7 during ACK -> ipl_n_out stays 2 until IDLE, then becomes 7 within 1 tick.
REQ-033 Reset test: reset pulsed during ACK (vpa_n=0) -> vpa_n=1 before the next clk edge, state IDLE, iack_done stays 0.

Source files
------------

// File: rtl/paula_iack_sequencer.sv
// Interrupt-acknowledge sequencer: debounces the IPL lines toward the CPU and
// answers CPU-space IACK cycles with a delayed autovector (VPA) or a bus error.
module paula_iack_sequencer #(
  parameter int VPA_DELAY = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk7_en,
  input  logic [2:0] ipl_n_in,
  input  logic       cpu_as_n,
  input  logic [2:0] cpu_fc,
  input  logic [2:0] cpu_addr,
  output logic [2:0] ipl_n_out,
  output logic       vpa_n,
  output logic       berr_n,
  output logic [2:0] iack_level,
  output logic       iack_done,
  output logic [1:0] o_dbg_state
);

  if (VPA_DELAY < 1 || VPA_DELAY > 15) begin : g_bad_delay
    $error("VPA_DELAY must be in 1..15");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2,
    S_SPUR = 2'd3
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(VPA_DELAY - 1);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_cnt;
  logic [2:0] r_sample;
  logic [2:0] r_ipl_out;
  logic [2:0] r_req_lvl;
  logic [2:0] r_iack_level;
  logic       w_iack_cycle;
  logic       w_req_ok;
  logic [2:0] w_pend_lvl;

  // Bus handshake: the CPU holds AS low for the whole acknowledge; the
  // sequencer answers with VPA (valid level) or BERR (spurious) and keeps that
  // strobe low until AS is seen high on a tick, which ends the transaction.
  assign w_iack_cycle = !cpu_as_n && (cpu_fc == 3'b111);
  assign w_pend_lvl   = ~r_ipl_out;
  assign w_req_ok     = (cpu_addr != 3'd0) && (cpu_addr <= w_pend_lvl);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else if (clk7_en) begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_iack_cycle) begin
          w_next = w_req_ok ? S_WAIT : S_SPUR;
        end
      end
      S_WAIT: begin
        if (cpu_as_n) begin
          w_next = S_IDLE;
        end else if (r_cnt == 4'd0) begin
          w_next = S_ACK;
        end
      end
      S_ACK, S_SPUR: begin
        if (cpu_as_n) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    vpa_n     = (r_state != S_ACK);
    berr_n    = (r_state != S_SPUR);
    iack_done = clk7_en && (r_state == S_ACK) && cpu_as_n;
  end

  // The filter keeps sampling during a transaction so a level that settled
  // meanwhile is released on the first idle tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sample  <= 3'b111;
      r_ipl_out <= 3'b111;
    end else if (clk7_en) begin
      r_sample <= ipl_n_in;
      if (r_state == S_IDLE && ipl_n_in == r_sample) begin
        r_ipl_out <= ipl_n_in;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt        <= 4'd0;
      r_req_lvl    <= 3'd0;
      r_iack_level <= 3'd0;
    end else if (clk7_en) begin
      if (r_state == S_IDLE && w_iack_cycle) begin
        r_req_lvl <= cpu_addr;
        r_cnt     <= CNT_LOAD;
      end else if (r_state == S_WAIT && !cpu_as_n && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (r_state == S_ACK && cpu_as_n) begin
        r_iack_level <= r_req_lvl;
      end
    end
  end

  assign ipl_n_out   = r_ipl_out;
  assign iack_level  = r_iack_level;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_paula_iack_sequencer.sv
// Bench for paula_iack_sequencer: transaction-level model compared every clk,
// plus hand-computed checkpoints along a directed scenario.
module tb_paula_iack_sequencer;

  localparam int VPA_DELAY = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clk7_en = 1'b0;
  logic [2:0] ipl_n_in = 3'b111;
  logic       cpu_as_n = 1'b1;
  logic [2:0] cpu_fc = 3'd0;
  logic [2:0] cpu_addr = 3'd0;
  logic [2:0] ipl_n_out, ipl_n_out1;
  logic       vpa_n, berr_n, iack_done, vpa_n1, berr_n1, iack_done1;
  logic [2:0] iack_level, iack_level1;
  logic [1:0] dbg_state, dbg_state1;

  int n_vec = 0;
  int n_miss = 0;
  int n_done = 0;
  int d0;

  // Transaction model: busy/good/ticks-since-detection instead of states.
  logic       m_busy = 1'b0;
  logic       m_good = 1'b0;
  int         m_ticks = 0;
  logic [2:0] m_lvl = 3'd0;
  logic [2:0] m_level = 3'd0;
  logic [2:0] m_prev = 3'b111;
  logic [2:0] m_ipl_out = 3'b111;

  paula_iack_sequencer dut (
    .clk(clk), .reset(reset), .clk7_en(clk7_en), .ipl_n_in(ipl_n_in),
    .cpu_as_n(cpu_as_n), .cpu_fc(cpu_fc), .cpu_addr(cpu_addr),
    .ipl_n_out(ipl_n_out), .vpa_n(vpa_n), .berr_n(berr_n),
    .iack_level(iack_level), .iack_done(iack_done), .o_dbg_state(dbg_state)
  );

  paula_iack_sequencer #(.VPA_DELAY(1)) dut1 (
    .clk(clk), .reset(reset), .clk7_en(clk7_en), .ipl_n_in(ipl_n_in),
    .cpu_as_n(cpu_as_n), .cpu_fc(cpu_fc), .cpu_addr(cpu_addr),
    .ipl_n_out(ipl_n_out1), .vpa_n(vpa_n1), .berr_n(berr_n1),
    .iack_level(iack_level1), .iack_done(iack_done1), .o_dbg_state(dbg_state1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_good = 1'b0; m_ticks = 0; m_lvl = 3'd0;
    m_level = 3'd0; m_prev = 3'b111; m_ipl_out = 3'b111;
  endtask

  task automatic model_tick();
    logic       was_busy;
    logic [2:0] pend;
    was_busy = m_busy;
    pend = ~m_ipl_out;
    if (!m_busy) begin
      if (!cpu_as_n && cpu_fc == 3'b111) begin
        m_busy = 1'b1;
        m_lvl = cpu_addr;
        m_good = (cpu_addr != 3'd0) && (cpu_addr <= pend);
        m_ticks = 0;
      end
    end else if (m_good && m_ticks < VPA_DELAY) begin
      if (cpu_as_n) m_busy = 1'b0;
      else m_ticks++;
    end else if (cpu_as_n) begin
      m_busy = 1'b0;
      if (m_good) m_level = m_lvl;
    end
    if (!was_busy && ipl_n_in == m_prev) m_ipl_out = ipl_n_in;
    m_prev = ipl_n_in;
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) model_reset();
    else if (clk7_en) model_tick();
  end

  // Compare process: every falling edge, DUT against the model.
  initial forever begin
    @(negedge clk);
    check("ipl_n_out", int'(ipl_n_out), int'(m_ipl_out));
    check("vpa_n", int'(vpa_n), int'(!(m_busy && m_good && m_ticks >= VPA_DELAY)));
    check("berr_n", int'(berr_n), int'(!(m_busy && !m_good)));
    check("iack_level", int'(iack_level), int'(m_level));
    check("iack_done", int'(iack_done),
          int'(m_busy && m_good && m_ticks >= VPA_DELAY && clk7_en && cpu_as_n && !reset));
    check("idle", int'(dbg_state == 2'd0), int'(!m_busy));
    check("vpa_berr_excl", int'(!vpa_n && !berr_n), 0);
    if (iack_done) n_done++;
  end

  task automatic tick();
    @(posedge clk); #1 clk7_en = 1'b1;
    @(posedge clk); #1 clk7_en = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
  endtask

  task automatic bus(input logic as_n, input logic [2:0] fc, input logic [2:0] addr);
    cpu_as_n = as_n; cpu_fc = fc; cpu_addr = addr;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_ipl", int'(ipl_n_out), 7);
    check("rst_vpa", int'(vpa_n), 1);
    check("rst_berr", int'(berr_n), 1);
    check("rst_level", int'(iack_level), 0);
    ipl_n_in = 3'd2; clk7_en = 1'b1;
    @(posedge clk); #1;
    check("rst_en_ipl", int'(ipl_n_out), 7);
    check("rst_state", int'(dbg_state), 0);
    clk7_en = 1'b0; ipl_n_in = 3'b111;
    @(posedge clk); #1 reset = 1'b0;

    // Glitch 7->3->7 must not reach the CPU.
    ipl_n_in = 3'd3; tick();
    ipl_n_in = 3'd7; tick();
    check("glitch_ipl", int'(ipl_n_out), 7);
    tick();
    check("glitch_ipl2", int'(ipl_n_out), 7);
    // 7->2 propagates on the second tick.
    ipl_n_in = 3'd2; tick();
    check("filt_tick1", int'(ipl_n_out), 7);
    tick();
    check("filt_tick2", int'(ipl_n_out), 2);

    // Ordinary bus cycle stays idle.
    bus(1'b0, 3'b110, 3'd5); tick(); tick();
    check("non_iack_idle", int'(dbg_state), 0);
    bus(1'b1, 3'b110, 3'd5); tick();

    // Autovector, level 5.
    bus(1'b0, 3'b111, 3'd5); tick();
    check("av_det_vpa", int'(vpa_n), 1);
    tick();
    check("av_t2_vpa", int'(vpa_n), 1);
    check("av_d1_vpa", int'(vpa_n1), 0);
    tick();
    check("av_t3_vpa", int'(vpa_n), 1);
    tick();
    check("av_t4_vpa", int'(vpa_n), 0);
    // Freeze: IPL changes during ACK.
    ipl_n_in = 3'd7; tick(); tick();
    check("freeze_ipl", int'(ipl_n_out), 2);
    d0 = n_done;
    bus(1'b1, 3'b111, 3'd5); tick();
    check("av_end_vpa", int'(vpa_n), 1);
    check("av_level", int'(iack_level), 5);
    check("av_done_cnt", n_done - d0, 1);
    check("av_d1_level", int'(iack_level1), 5);
    tick();
    check("unfreeze_ipl", int'(ipl_n_out), 7);

    // Spurious: pending level 3.
    bus(1'b1, 3'd0, 3'd0);
    ipl_n_in = 3'd4; tick(); tick();
    check("pend3_ipl", int'(ipl_n_out), 4);
    d0 = n_done;
    bus(1'b0, 3'b111, 3'd6); tick();
    check("sp6_berr", int'(berr_n), 0);
    check("sp6_vpa", int'(vpa_n), 1);
    tick();
    check("sp6_hold", int'(berr_n), 0);
    bus(1'b1, 3'b111, 3'd6); tick();
    check("sp6_rel", int'(berr_n), 1);
    bus(1'b0, 3'b111, 3'd0); tick();
    check("sp0_berr", int'(berr_n), 0);
    bus(1'b1, 3'b111, 3'd0); tick();
    bus(1'b0, 3'b111, 3'd4); tick();
    check("sp4_berr", int'(berr_n), 0);
    bus(1'b1, 3'b111, 3'd4); tick();
    check("sp_done_cnt", n_done - d0, 0);
    check("sp_level", int'(iack_level), 5);

    // Abort during WAIT.
    bus(1'b0, 3'b111, 3'd2); tick(); tick();
    bus(1'b1, 3'b111, 3'd2); tick();
    check("abort_idle", int'(dbg_state), 0);
    check("abort_vpa", int'(vpa_n), 1);
    check("abort_level", int'(iack_level), 5);
    tick();

    // Request equal to pending level is honoured.
    bus(1'b0, 3'b111, 3'd3);
    repeat (4) tick();
    check("eq_vpa", int'(vpa_n), 0);
    bus(1'b1, 3'b111, 3'd3); tick();
    check("eq_level", int'(iack_level), 3);
    tick();

    // Reset in the middle of ACK.
    bus(1'b0, 3'b111, 3'd3);
    repeat (4) tick();
    check("pre_rst_vpa", int'(vpa_n), 0);
    d0 = n_done;
    @(posedge clk); #3 reset = 1'b1;
    #1;
    check("mid_rst_vpa", int'(vpa_n), 1);
    check("mid_rst_state", int'(dbg_state), 0);
    check("mid_rst_done", int'(iack_done), 0);
    bus(1'b1, 3'd0, 3'd0);
    tick();
    check("rst_done_cnt", n_done - d0, 0);
    check("rst_level0", int'(iack_level), 0);
    reset = 1'b0;
    tick(); tick();
    check("post_rst_ipl", int'(ipl_n_out), 4);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
